// File: rtl/uart_pkg.sv
// Shared types for the UART transmit feeder: the issue FSM state encoding.
package uart_pkg;

  typedef enum logic [1:0] {
    S_SYNC,
    S_IDLE,
    S_WAIT_DONE,
    S_WAIT_CLR
  } feeder_state_t;

  localparam int unsigned FEEDER_DEPTH = 16;

endpackage

// File: rtl/uart_byte_fifo.sv
// Synchronous byte FIFO with registered full/empty and occupancy count.
// Storage is intentionally left unreset; only pointers and flags clear.
module uart_byte_fifo #(
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  output logic [7:0]    head,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          push_ok;
  logic          pop_ok;

  // Gating on the registered flags means a write while full is dropped even if a pop frees a slot.
  assign push_ok = push && !full_q;
  assign pop_ok  = pop && !empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
    else if (!push_ok && pop_ok) count_d = count_q - 1'b1;
    full_d  = (count_d == DEPTH_CNT);
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= push_data;
  end

  assign head  = mem[rd_ptr_q];
  assign count = count_q;
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers producer bytes and hands them to the UART transmitter one frame at a time,
// issuing the next byte only once the previous frame has fully completed.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter  int unsigned DEPTH = FEEDER_DEPTH,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          i_Clock,
  input  logic          i_Rst_L,
  input  logic          i_Wr_DV,
  input  logic [7:0]    i_Wr_Byte,
  output logic          o_Full,
  output logic          o_Empty,
  output logic [AW:0]   o_Count,
  output logic          o_Overflow,
  output logic          o_Idle,
  output logic          o_Tx_DV,
  output logic [7:0]    o_Tx_Byte,
  input  logic          i_Tx_Active,
  input  logic          i_Tx_Done
);

  feeder_state_t state_q, state_d;
  logic          tx_dv_q, tx_dv_d;
  logic [7:0]    tx_byte_q, tx_byte_d;
  logic          overflow_q, overflow_d;
  logic          fifo_pop;
  logic [7:0]    fifo_head;
  logic          fifo_full;
  logic          fifo_empty;

  uart_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (i_Clock),
    .rst_n     (i_Rst_L),
    .push      (i_Wr_DV),
    .push_data (i_Wr_Byte),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (o_Count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // The transmitter has no reset, so after our reset we wait for it to go quiet before issuing.
  always_comb begin
    state_d    = state_q;
    tx_dv_d    = 1'b0;
    tx_byte_d  = tx_byte_q;
    fifo_pop   = 1'b0;
    overflow_d = i_Wr_DV && fifo_full;
    case (state_q)
      S_SYNC: begin
        if (!i_Tx_Active && !i_Tx_Done) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (!fifo_empty) begin
          tx_dv_d   = 1'b1;
          tx_byte_d = fifo_head;
          fifo_pop  = 1'b1;
          state_d   = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (i_Tx_Done) state_d = S_WAIT_CLR;
      end
      S_WAIT_CLR: begin
        if (!i_Tx_Done) state_d = S_IDLE;
      end
      default: state_d = S_SYNC;
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q    <= S_SYNC;
      tx_dv_q    <= 1'b0;
      tx_byte_q  <= 8'h00;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_dv_q    <= tx_dv_d;
      tx_byte_q  <= tx_byte_d;
      overflow_q <= overflow_d;
    end
  end

  assign o_Full     = fifo_full;
  assign o_Empty    = fifo_empty;
  assign o_Overflow = overflow_q;
  assign o_Tx_DV    = tx_dv_q;
  assign o_Tx_Byte  = tx_byte_q;
  assign o_Idle     = (state_q == S_IDLE) && fifo_empty;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench: feeder paired with a behavioural UART transmitter (4 clocks per bit)
// and a line receiver that decodes every frame actually put on the wire.
module tb_uart_tx_feeder;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       wr_dv = 1'b0;
  logic [7:0] wr_byte = 8'h00;
  logic       o_full, o_empty, o_overflow, o_idle, o_tx_dv;
  logic [4:0] o_count;
  logic [7:0] o_tx_byte;
  logic       tx_active = 1'b0;
  logic       tx_done = 1'b0;
  logic       tx_line = 1'b1;

  int testsRun = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  uart_tx_feeder #(.DEPTH(16)) dut (
    .i_Clock     (clk),
    .i_Rst_L     (rst_n),
    .i_Wr_DV     (wr_dv),
    .i_Wr_Byte   (wr_byte),
    .o_Full      (o_full),
    .o_Empty     (o_empty),
    .o_Count     (o_count),
    .o_Overflow  (o_overflow),
    .o_Idle      (o_idle),
    .o_Tx_DV     (o_tx_dv),
    .o_Tx_Byte   (o_tx_byte),
    .i_Tx_Active (tx_active),
    .i_Tx_Done   (tx_done)
  );

  // Transmitter model: no reset, done held for two cycles (stop end plus cleanup).
  int         txState = 0;
  int         txCnt = 0;
  int         txBit = 0;
  logic [7:0] txData = 8'h00;

  always @(posedge clk) begin
    case (txState)
      0: begin
        tx_done <= 1'b0;
        tx_line <= 1'b1;
        if (o_tx_dv) begin
          txData    <= o_tx_byte;
          tx_active <= 1'b1;
          tx_line   <= 1'b0;
          txCnt     <= 0;
          txState   <= 1;
        end
      end
      1: begin
        if (txCnt < CPB-1) txCnt <= txCnt + 1;
        else begin
          txCnt   <= 0;
          txBit   <= 0;
          tx_line <= txData[0];
          txState <= 2;
        end
      end
      2: begin
        if (txCnt < CPB-1) txCnt <= txCnt + 1;
        else begin
          txCnt <= 0;
          if (txBit < 7) begin
            txBit   <= txBit + 1;
            tx_line <= txData[txBit+1];
          end else begin
            tx_line <= 1'b1;
            txState <= 3;
          end
        end
      end
      3: begin
        if (txCnt < CPB-1) txCnt <= txCnt + 1;
        else begin
          txCnt     <= 0;
          tx_done   <= 1'b1;
          tx_active <= 1'b0;
          txState   <= 4;
        end
      end
      default: begin
        tx_done <= 1'b1;
        txState <= 0;
      end
    endcase
  end

  // Line receiver: samples mid-bit, start at sample 2, bit k at 6+4k, stop at 38.
  logic       rxBusy = 1'b0;
  int         rxCnt = 0;
  int         rxErr = 0;
  logic [7:0] rxShift = 8'h00;
  logic [7:0] rxQ[$];

  always @(negedge clk) begin
    if (!rxBusy) begin
      if (!tx_line) begin
        rxBusy <= 1'b1;
        rxCnt  <= 0;
      end
    end else begin
      rxCnt <= rxCnt + 1;
      if (rxCnt == 1 && tx_line) rxErr <= rxErr + 1;
      if (rxCnt >= 5 && rxCnt <= 33 && ((rxCnt - 5) % 4) == 0) rxShift <= {tx_line, rxShift[7:1]};
      if (rxCnt == 37) begin
        if (!tx_line) rxErr <= rxErr + 1;
        rxQ.push_back(rxShift);
        rxBusy <= 1'b0;
      end
    end
  end

  // DV watcher: pulse count, DV while transmitter busy, DV wider than one cycle,
  // and the number of samples between done first reading low and the next DV.
  logic prevDv = 1'b0;
  int   dvCount = 0;
  int   dvViol = 0;
  int   dvWide = 0;
  logic gapArmed = 1'b0;
  int   gapCnt = 0;
  int   gapQ[$];

  always @(negedge clk) begin
    prevDv <= o_tx_dv;
    if (o_tx_dv) begin
      dvCount <= dvCount + 1;
      if (tx_active) dvViol <= dvViol + 1;
      if (prevDv)    dvWide <= dvWide + 1;
      if (gapArmed)  gapQ.push_back(gapCnt);
    end
    if (tx_done) begin
      gapArmed <= 1'b1;
      gapCnt   <= 0;
    end else if (gapArmed) begin
      gapCnt <= gapCnt + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    wr_dv   = 1'b1;
    wr_byte = b;
    @(negedge clk);
    wr_dv   = 1'b0;
  endtask

  function automatic logic [8:0] rxAt(input int i);
    if (i < rxQ.size()) return {1'b0, rxQ[i]};
    return 9'h100;
  endfunction

  task automatic waitIdle(input int budget);
    int n;
    n = 0;
    repeat (2) @(negedge clk);
    while (!(o_idle && !rxBusy && !tx_active && !tx_done) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("idle_reached", 32'(n < budget), 32'd1);
  endtask

  task automatic waitDone(input logic level, input int budget);
    int n;
    n = 0;
    while (tx_done !== level && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("done_wait", 32'(n < budget), 32'd1);
  endtask

  int rxBase, dvBase, gapBase;

  initial begin
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_empty", 32'(o_empty), 32'd1);
    checkOutput("rst_full", 32'(o_full), 32'd0);
    checkOutput("rst_count", 32'(o_count), 32'd0);
    checkOutput("rst_ovf", 32'(o_overflow), 32'd0);
    checkOutput("rst_dv", 32'(o_tx_dv), 32'd0);
    checkOutput("rst_byte", 32'(o_tx_byte), 32'h00);
    checkOutput("rst_idle", 32'(o_idle), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("sync_to_idle", 32'(o_idle), 32'd1);

    // Single byte into an empty FIFO: DV one edge after the write edge, one cycle wide.
    rxBase = rxQ.size();
    applyStimulus(8'hA5);
    checkOutput("t1_dv_early", 32'(o_tx_dv), 32'd0);
    checkOutput("t1_count", 32'(o_count), 32'd1);
    checkOutput("t1_empty", 32'(o_empty), 32'd0);
    @(negedge clk);
    checkOutput("t1_dv", 32'(o_tx_dv), 32'd1);
    checkOutput("t1_byte", 32'(o_tx_byte), 32'hA5);
    checkOutput("t1_count_pop", 32'(o_count), 32'd0);
    checkOutput("t1_busy_idle", 32'(o_idle), 32'd0);
    @(negedge clk);
    checkOutput("t1_dv_fall", 32'(o_tx_dv), 32'd0);
    waitIdle(200);
    checkOutput("t1_rx_n", 32'(rxQ.size() - rxBase), 32'd1);
    checkOutput("t1_rx", 32'(rxAt(rxBase)), 32'h0A5);

    // Prime a frame so the FSM is busy, then fill all 16 slots and overflow once.
    rxBase = rxQ.size();
    dvBase = dvCount;
    applyStimulus(8'hF0);
    @(negedge clk);
    wr_dv = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      wr_byte = 8'(i);
      @(negedge clk);
    end
    wr_dv = 1'b0;
    checkOutput("t2_full", 32'(o_full), 32'd1);
    checkOutput("t2_count", 32'(o_count), 32'd16);
    applyStimulus(8'hEE);
    checkOutput("t3_ovf", 32'(o_overflow), 32'd1);
    checkOutput("t3_count", 32'(o_count), 32'd16);
    @(negedge clk);
    checkOutput("t3_ovf_fall", 32'(o_overflow), 32'd0);
    waitIdle(1500);
    checkOutput("t2_rx_n", 32'(rxQ.size() - rxBase), 32'd17);
    checkOutput("t2_rx0", 32'(rxAt(rxBase)), 32'h0F0);
    for (int i = 1; i <= 16; i++)
      checkOutput($sformatf("t2_rx%0d", i), 32'(rxAt(rxBase + i)), 32'(i));
    checkOutput("t2_dv_n", 32'(dvCount - dvBase), 32'd17);

    // Streaming with the FIFO never empty; leaves the write pointer at 13 for the wrap test.
    rxBase  = rxQ.size();
    gapBase = gapQ.size();
    wr_dv = 1'b1;
    for (int i = 0; i < 11; i++) begin
      wr_byte = 8'h20 + 8'(i);
      @(negedge clk);
    end
    wr_dv = 1'b0;
    waitIdle(1000);
    checkOutput("t6_rx_n", 32'(rxQ.size() - rxBase), 32'd11);
    for (int i = 0; i < 11; i++)
      checkOutput($sformatf("t6_rx%0d", i), 32'(rxAt(rxBase + i)), 32'h20 + 32'(i));
    // Done is first sampled low by the FSM on the next edge; DV is registered one edge later.
    for (int i = 1; i < 11; i++)
      checkOutput($sformatf("t6_gap%0d", i),
                  32'((gapBase + i < gapQ.size()) ? gapQ[gapBase + i] : -1), 32'd2);

    // Push and pop on the same edge at count 3, with slots 13,14,15,0,1 in use.
    rxBase = rxQ.size();
    applyStimulus(8'h40);
    wr_dv = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      wr_byte = 8'h40 + 8'(i);
      @(negedge clk);
    end
    wr_dv = 1'b0;
    checkOutput("t4_count_pre", 32'(o_count), 32'd3);
    waitDone(1'b1, 200);
    waitDone(1'b0, 20);
    @(negedge clk);
    applyStimulus(8'h44);
    checkOutput("t4_count_same", 32'(o_count), 32'd3);
    checkOutput("t4_dv", 32'(o_tx_dv), 32'd1);
    checkOutput("t4_byte", 32'(o_tx_byte), 32'h41);
    waitIdle(600);
    checkOutput("t4_rx_n", 32'(rxQ.size() - rxBase), 32'd5);
    for (int i = 0; i < 5; i++)
      checkOutput($sformatf("t4_rx%0d", i), 32'(rxAt(rxBase + i)), 32'h40 + 32'(i));

    // Reset during a data bit of frame 3C with four bytes queued.
    rxBase = rxQ.size();
    applyStimulus(8'h3C);
    wr_dv = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_byte = 8'h50 + 8'(i);
      @(negedge clk);
    end
    wr_dv = 1'b0;
    checkOutput("t5_count_q", 32'(o_count), 32'd4);
    repeat (10) @(negedge clk);
    checkOutput("t5_midframe", 32'(tx_active), 32'd1);
    dvBase = dvCount;
    rst_n = 1'b0;
    #1;
    checkOutput("t5_rst_count", 32'(o_count), 32'd0);
    checkOutput("t5_rst_empty", 32'(o_empty), 32'd1);
    checkOutput("t5_rst_idle", 32'(o_idle), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("t5_sync_hold", 32'(o_idle), 32'd0);
    waitIdle(200);
    checkOutput("t5_no_dv", 32'(dvCount - dvBase), 32'd0);
    checkOutput("t5_rx_n", 32'(rxQ.size() - rxBase), 32'd1);
    checkOutput("t5_rx_3c", 32'(rxAt(rxBase)), 32'h03C);
    applyStimulus(8'h77);
    waitIdle(200);
    checkOutput("t5_dv_n", 32'(dvCount - dvBase), 32'd1);
    checkOutput("t5_rx_n2", 32'(rxQ.size() - rxBase), 32'd2);
    checkOutput("t5_rx_77", 32'(rxAt(rxBase + 1)), 32'h077);

    checkOutput("dv_while_active", 32'(dvViol), 32'd0);
    checkOutput("dv_width", 32'(dvWide), 32'd0);
    checkOutput("line_framing", 32'(rxErr), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
